// File: rtl/imm_pack.sv
// rtl/imm_pack.sv - two-stage immediate packer, inverse of the 5/8/11-bit immediate extender
// S1 holds the raw request, S2 holds the packed field and its representability flag.
module imm_pack (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] imm,
  input  logic [1:0]  select,
  input  logic        op,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [10:0] instr,
  output logic        err,
  output logic [7:0]  err_cnt
);

  logic        s1_valid_q, s1_valid_d;
  logic [15:0] s1_imm_q, s1_imm_d;
  logic [1:0]  s1_sel_q, s1_sel_d;
  logic        s1_op_q, s1_op_d;
  logic        s2_valid_q, s2_valid_d;
  logic [10:0] instr_q, instr_d;
  logic        err_q, err_d;
  logic [7:0]  err_cnt_q, err_cnt_d;

  logic        s2_load, s1_move, in_fire, out_fire;
  logic [15:0] mask_z, mask_s, upper_s;
  logic        sel_legal;
  logic [10:0] pack_instr;
  logic        pack_err;

  // mask_z covers bits that must be zero for zero-extension; mask_s covers
  // the sign bit plus everything above it, which must all match for sign-extension.
  always_comb begin
    mask_z    = 16'h0000;
    mask_s    = 16'h0000;
    sel_legal = 1'b1;
    case (s1_sel_q)
      2'b00:   begin mask_z = 16'hFFE0; mask_s = 16'hFFF0; end
      2'b01:   begin mask_z = 16'hFF00; mask_s = 16'hFF80; end
      2'b10:   begin mask_z = 16'hF800; mask_s = 16'hFC00; end
      default: sel_legal = 1'b0;
    endcase
  end

  always_comb begin
    upper_s    = s1_imm_q & mask_s;
    pack_instr = 11'h000;
    pack_err   = 1'b1;
    if (sel_legal) begin
      pack_instr = s1_imm_q[10:0] & ~mask_z[10:0];
      if (s1_op_q)
        pack_err = (upper_s != 16'h0000) && (upper_s != mask_s);
      else
        pack_err = (s1_imm_q & mask_z) != 16'h0000;
    end
  end

  always_comb begin
    s2_load  = !s2_valid_q || out_ready;
    s1_move  = s1_valid_q && s2_load;
    in_ready = rst_n && (!s1_valid_q || s2_load);
    in_fire  = in_valid && in_ready;
    out_fire = s2_valid_q && out_ready;

    s1_valid_d = s1_valid_q;
    s1_imm_d   = s1_imm_q;
    s1_sel_d   = s1_sel_q;
    s1_op_d    = s1_op_q;
    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_imm_d   = imm;
      s1_sel_d   = select;
      s1_op_d    = op;
    end else if (s1_move) begin
      s1_valid_d = 1'b0;
    end

    s2_valid_d = s2_valid_q;
    instr_d    = instr_q;
    err_d      = err_q;
    if (s2_load) s2_valid_d = s1_valid_q;
    if (s1_move) begin
      instr_d = pack_instr;
      err_d   = pack_err;
    end

    err_cnt_d = err_cnt_q;
    if (out_fire && err_q && (err_cnt_q != 8'hFF))
      err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_imm_q   <= 16'h0000;
      s1_sel_q   <= 2'b00;
      s1_op_q    <= 1'b0;
      s2_valid_q <= 1'b0;
      instr_q    <= 11'h000;
      err_q      <= 1'b0;
      err_cnt_q  <= 8'h00;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_imm_q   <= s1_imm_d;
      s1_sel_q   <= s1_sel_d;
      s1_op_q    <= s1_op_d;
      s2_valid_q <= s2_valid_d;
      instr_q    <= instr_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign instr     = instr_q;
  assign err       = err_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_imm_pack.sv
// tb/tb_imm_pack.sv - scoreboard bench for imm_pack
module tb_imm_pack;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] imm;
  logic [1:0]  select;
  logic        op;
  logic        out_valid;
  logic        out_ready;
  logic [10:0] instr;
  logic        err;
  logic [7:0]  err_cnt;

  imm_pack dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .imm(imm), .select(select), .op(op), .out_valid(out_valid),
    .out_ready(out_ready), .instr(instr), .err(err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fails  = 0;
  logic [11:0] sb[$];
  int          exp_cnt  = 0;
  logic        last_in_fire;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] model(input logic [15:0] v, input logic [1:0] s, input logic o);
    int w;
    logic bad;
    logic [10:0] r;
    if (s == 2'b11) return {1'b1, 11'h000};
    w = (s == 2'b00) ? 5 : (s == 2'b01) ? 8 : 11;
    r = '0;
    for (int i = 0; i < w; i++) r[i] = v[i];
    bad = 1'b0;
    if (!o) begin
      for (int i = w; i < 16; i++) if (v[i]) bad = 1'b1;
    end else begin
      for (int i = w - 1; i < 16; i++) if (v[i] !== v[15]) bad = 1'b1;
    end
    return {bad, r};
  endfunction

  task automatic cycle();
    logic [11:0] e;
    #1;
    last_in_fire = in_valid && in_ready && rst_n;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) check("sb_underflow", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        check("out_instr", {21'd0, instr}, {21'd0, e[10:0]});
        check("out_err", {31'd0, err}, {31'd0, e[11]});
        if (e[11] && exp_cnt != 255) exp_cnt++;
      end
    end
    if (last_in_fire) sb.push_back(model(imm, select, op));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    imm      = 'x;
    select   = 'x;
    op       = 1'bx;
  endtask

  task automatic drive(input logic [15:0] v, input logic [1:0] s, input logic o);
    in_valid = 1'b1;
    imm      = v;
    select   = s;
    op       = o;
  endtask

  task automatic send(input logic [15:0] v, input logic [1:0] s, input logic o);
    int n = 0;
    drive(v, s, o);
    do begin
      cycle();
      n++;
    end while (!last_in_fire && n < 50);
    if (!last_in_fire) check("send_timeout", 32'd0, 32'd1);
    idle();
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      cycle();
      n++;
    end
    check("drain_empty", sb.size(), 32'd0);
    #1;
    check("err_cnt", {24'd0, err_cnt}, exp_cnt);
  endtask

  logic [15:0] r_imm[4] = '{16'h0015, 16'hFFF5, 16'h0080, 16'h1234};
  logic [1:0]  r_sel[4] = '{2'b00, 2'b00, 2'b01, 2'b10};
  logic        r_op[4]  = '{1'b0, 1'b1, 1'b0, 1'b0};

  initial begin
    int idx;
    int n;
    int acc;
    logic [11:0] e0;

    rst_n = 1'b0;
    out_ready = 1'b0;
    idle();
    @(negedge clk);
    cycle();
    cycle();
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_instr", {21'd0, instr}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;

    send(16'h0015, 2'b00, 1'b0);
    check("lat_c1_out_valid", {31'd0, out_valid}, 32'd0);
    cycle();
    check("lat_c2_out_valid", {31'd0, out_valid}, 32'd1);
    check("lat_instr", {21'd0, instr}, 32'h015);
    drain();

    send(16'hFFF5, 2'b00, 1'b1);
    send(16'hFFF5, 2'b00, 1'b0);
    send(16'h0080, 2'b01, 1'b1);
    send(16'h0080, 2'b01, 1'b0);
    send(16'hFC00, 2'b10, 1'b1);
    send(16'h03FF, 2'b10, 1'b1);
    send(16'h0400, 2'b10, 1'b0);
    send(16'hFFEF, 2'b00, 1'b1);
    drain();

    // 300 illegal-select requests streamed back-to-back
    acc = 0;
    n = 0;
    while (acc < 300 && n < 1000) begin
      drive(16'($urandom), 2'b11, 1'($urandom));
      cycle();
      if (last_in_fire) acc++;
      n++;
    end
    check("sat_accepted", acc, 32'd300);
    idle();
    drain();
    check("sat_err_cnt_ff", {24'd0, err_cnt}, 32'hFF);

    out_ready = 1'b0;
    idx = 0;
    for (int k = 0; k < 2; k++) begin
      drive(r_imm[idx], r_sel[idx], r_op[idx]);
      cycle();
      if (last_in_fire) idx++;
    end
    check("stall_acc2", idx, 32'd2);
    e0 = model(r_imm[0], r_sel[0], r_op[0]);
    drive(r_imm[idx], r_sel[idx], r_op[idx]);
    for (int k = 0; k < 5; k++) begin
      #1;
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      check("stall_out_valid", {31'd0, out_valid}, 32'd1);
      check("stall_instr", {21'd0, instr}, {21'd0, e0[10:0]});
      check("stall_err", {31'd0, err}, {31'd0, e0[11]});
      cycle();
    end
    out_ready = 1'b1;
    #1;
    check("resume_in_ready", {31'd0, in_ready}, 32'd1);
    n = 0;
    while ((idx < 4 || sb.size() != 0) && n < 40) begin
      if (idx < 4) drive(r_imm[idx], r_sel[idx], r_op[idx]);
      else idle();
      cycle();
      if (last_in_fire && idx < 4) idx++;
      n++;
    end
    check("stall_all_sent", idx, 32'd4);
    idle();
    drain();

    out_ready = 1'b0;
    send(16'h7777, 2'b00, 1'b0);
    send(16'h8000, 2'b01, 1'b0);
    rst_n = 1'b0;
    out_ready = 1'b1;
    cycle();
    rst_n = 1'b1;
    sb.delete();
    exp_cnt = 0;
    #1;
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_err_cnt", {24'd0, err_cnt}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    send(16'hFFFF, 2'b01, 1'b1);
    send(16'h0100, 2'b01, 1'b0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/imm_pack.md
IMM_PACK -- requirements
Module: imm_pack

Interface
REQ-001 The block SHALL have the ports below, clock and reset first; the clock is one clock, clk, and the reset is synchronous, active-low, rst_n.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
REQ-004 in_valid  input  1  request carries a valid immediate.
REQ-005 in_ready  output  1  block accepts request this cycle.
REQ-006 imm  input  16  full-width immediate to pack.
REQ-007 select  input  2  field format: 00=5-bit, 01=8-bit, 10=11-bit, 11=illegal.
REQ-008 op  input  1  extension mode: 0=zero-extend, 1=sign-extend.
REQ-009 out_valid  output  1  packed result available.
REQ-010 out_ready  input  1  consumer takes result this cycle.
REQ-011 instr  output  11  packed field, right-justified; bits above field width are 0.
REQ-012 err  output  1  result not representable or select illegal; qualified by out_valid.
REQ-013 err_cnt  output  8  saturating count of err results delivered.

Function
REQ-014 Packing is the exact inverse of the immediate extender: extending instr with the same select/op SHALL reproduce imm whenever err=0.
REQ-015 Field width W SHALL be 5, 8 or 11 for select 00, 01, 10; instr[W-1:0]=imm[W-1:0], instr[10:W]=0.
REQ-016 With op=0, err SHALL be 1 iff imm[15:W] is not all zero.
REQ-017 With op=1, err SHALL be 1 iff imm[15:W-1] is neither all zero nor all one.
REQ-018 select=11 SHALL give err=1 and instr=0, regardless of imm and op.
REQ-019 When err=1 for select 00..10, instr SHALL still carry imm[W-1:0] (truncated), upper bits 0.
REQ-020 Pipeline SHALL be two register stages: S1 captures imm/select/op, S2 holds computed instr/err; out_valid/instr/err come from S2 only.
REQ-021 Transfer in SHALL occur on a cycle with in_valid=1 and in_ready=1; transfer out on a cycle with out_valid=1 and out_ready=1.
REQ-022 Latency from input transfer to out_valid SHALL be 2 cycles when out_ready stays 1; sustained throughput is one result per cycle.
REQ-023 S2 SHALL load from S1 when S2 is empty or transferring out this cycle; S1 SHALL load when S1 is empty or moving into S2 this cycle.
REQ-024 in_ready SHALL be 1 iff S1 is empty or S1 moves to S2 this cycle (combinational from out_ready allowed; no in_valid-to-in_ready path).
REQ-025 While out_valid=1 and out_ready=0, instr and err SHALL hold stable; no request is dropped or duplicated.
REQ-026 With both stages full and out_ready=0, in_ready SHALL be 0; when out_ready rises, S2 drains, S1 advances and a new input is accepted in the same cycle.
REQ-027 err_cnt SHALL increment by 1 on each output transfer with err=1, saturating at 8'hFF.
REQ-028 Input signals SHALL be ignored when in_valid=0; X on imm/select/op with in_valid=0 SHALL not reach state.

Reset
REQ-029 On a rising clk with rst_n=0, both stages SHALL be emptied: out_valid=0, instr=0, err=0, err_cnt=0.
REQ-030 During reset, in_ready SHALL be 0; the first input may be accepted on the first cycle with rst_n=1.
REQ-031 Reset asserted mid-stream SHALL discard in-flight requests; no output transfer occurs in the reset cycle.

Verification
REQ-032 imm=16'h0015, select=00, op=0, out_ready=1 -> 2 cycles later instr=11'h015, err=0.
REQ-033 imm=16'hFFF5, select=00, op=1 -> instr=11'h015, err=0; same imm with op=0 -> err=1, instr=11'h015, err_cnt +1.
REQ-034 imm=16'h0080, select=01, op=1 -> err=1; op=0 -> instr=11'h080, err=0; imm=16'hFC00, select=10, op=1 -> instr=11'h400, err=0.
REQ-035 select=11, any imm/op -> err=1, instr=0; send 300 such requests -> err_cnt stops at 8'hFF.
REQ-036 Stream 4 back-to-back requests, hold out_ready=0 for 5 cycles then 1 -> in_ready=0 after 2 accepted, outputs stable while stalled, all 4 delivered in order, none lost.
REQ-037 Assert rst_n=0 for one cycle with both stages full -> next cycle out_valid=0, err_cnt=0, in_ready=1.
